// File: rtl/alu_regfile_stepper.sv
// Single-clock ALU + register file. Each rising edge of `step` runs one
// read -> execute -> writeback sequence through a four-state FSM.
module alu_regfile_stepper #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            step,
   input  logic [AW-1:0]   r_addr_a,
   input  logic [AW-1:0]   r_addr_b,
   input  logic [AW-1:0]   w_addr,
   input  logic [3:0]      alu_op,
   input  logic            w_en,
   input  logic            mode,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] res,
   output logic [3:0]      flags,
   output logic            busy,
   output logic            done
);

   localparam int SHW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t          state;
   logic            step_q;
   logic [AW-1:0]   a_q, b_q, w_q;
   logic [3:0]      op_q;
   logic            wen_q, mode_q;
   logic [XLEN-1:0] imm_q, opa, opb;
   logic [XLEN-1:0] regs [NREG];

   logic [XLEN-1:0] alu_res;
   logic            alu_c, alu_v;
   logic [XLEN:0]   sum, diff;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      sum     = {1'b0, opa} + {1'b0, opb};
      diff    = {1'b0, opa} - {1'b0, opb};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      if (mode_q) begin
         alu_res = imm_q;
      end else begin
         case (op_q)
            4'd0: begin
               alu_res = sum[XLEN-1:0];
               alu_c   = sum[XLEN];
               alu_v   = (opa[XLEN-1] == opb[XLEN-1]) && (sum[XLEN-1] != opa[XLEN-1]);
            end
            4'd1: begin
               // The extra top bit of the widened difference is the borrow.
               alu_res = diff[XLEN-1:0];
               alu_c   = diff[XLEN];
               alu_v   = (opa[XLEN-1] != opb[XLEN-1]) && (diff[XLEN-1] != opa[XLEN-1]);
            end
            4'd2:    alu_res = opa & opb;
            4'd3:    alu_res = opa | opb;
            4'd4:    alu_res = opa ^ opb;
            4'd5:    alu_res = opa << opb[SHW-1:0];
            4'd6:    alu_res = opa >> opb[SHW-1:0];
            4'd7:    alu_res = $signed(opa) >>> opb[SHW-1:0];
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
            4'd10:   alu_res = opa;
            4'd11:   alu_res = ~(opa | opb);
            default: alu_res = '0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         step_q <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         w_q    <= '0;
         op_q   <= '0;
         wen_q  <= 1'b0;
         mode_q <= 1'b0;
         imm_q  <= '0;
         opa    <= '0;
         opb    <= '0;
         res    <= '0;
         flags  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         // NOTE: the register file is reset too, because a cleared file is part
         // of the visible reset state; this keeps it in flops, not RAM.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         step_q <= step;
         case (state)
            IDLE: begin
               if (step && !step_q) begin
                  a_q    <= r_addr_a;
                  b_q    <= r_addr_b;
                  w_q    <= w_addr;
                  op_q   <= alu_op;
                  wen_q  <= w_en;
                  mode_q <= mode;
                  imm_q  <= imm;
                  busy   <= 1'b1;
                  state  <= READ;
               end
            end
            READ: begin
               opa   <= (a_q == '0) ? '0 : regs[a_q];
               opb   <= (b_q == '0) ? '0 : regs[b_q];
               state <= EXEC;
            end
            EXEC: begin
               res   <= alu_res;
               flags <= {(alu_res == '0), alu_res[XLEN-1], alu_c, alu_v};
               done  <= 1'b1;
               state <= WB;
            end
            WB: begin
               if (wen_q && (w_q != '0)) regs[w_q] <= res;
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_regfile_stepper.sv
// Randomised + directed bench for alu_regfile_stepper: a reference model
// predicts {res, flags} per step and a monitor compares on every done pulse.
module tb_alu_regfile_stepper;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        step = 1'b0;
   logic [4:0]  r_addr_a = '0, r_addr_b = '0, w_addr = '0;
   logic [3:0]  alu_op = '0;
   logic        w_en = 1'b0, mode = 1'b0;
   logic [31:0] imm = '0;
   logic [31:0] res;
   logic [3:0]  flags;
   logic        busy, done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] mregs [32];
   logic [35:0] exp_q [$];

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   alu_regfile_stepper dut (
      .clk(clk), .rst_n(rst_n), .step(step),
      .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .w_addr(w_addr),
      .alu_op(alu_op), .w_en(w_en), .mode(mode), .imm(imm),
      .res(res), .flags(flags), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference: plain integer arithmetic on the operation's definition.
   function automatic logic [35:0] ref_op(input logic [3:0] op, input logic m,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] k);
      logic [31:0] r;
      logic        c, v;
      longint      s;
      int          sh;
      c  = 1'b0;
      v  = 1'b0;
      r  = '0;
      sh = int'(b % 32);
      if (m) r = k;
      else begin
         case (op)
            4'd0: begin
               r = a + b;
               c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
               s = longint'($signed(a)) + longint'($signed(b));
               v = (s > SMAX) || (s < SMIN);
            end
            4'd1: begin
               r = a - b;
               c = a < b;
               s = longint'($signed(a)) - longint'($signed(b));
               v = (s > SMAX) || (s < SMIN);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = $signed(a) >>> sh;
            4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: r = a;
            4'd11: r = ~(a | b);
            default: r = '0;
         endcase
      end
      return {r, (r == 0), r[31], c, v};
   endfunction

   // Drives one operation and raises step at a negedge; optionally predicts it.
   task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                        input logic [3:0] op, input logic wen, input logic m,
                        input logic [31:0] k, input logic predict);
      logic [35:0] e;
      @(negedge clk);
      r_addr_a = a; r_addr_b = b; w_addr = w;
      alu_op = op; w_en = wen; mode = m; imm = k;
      step = 1'b1;
      if (predict) begin
         e = ref_op(op, m, mregs[a], mregs[b], k);
         exp_q.push_back(e);
         if (wen && w != 0) mregs[w] = e[35:4];
      end
   endtask

   // Drops step, scrambles inputs (must already be latched), waits for idle.
   task automatic finish_op();
      @(negedge clk);
      step = 1'b0;
      r_addr_a = 5'($urandom); r_addr_b = 5'($urandom); w_addr = 5'($urandom);
      alu_op = 4'($urandom); mode = 1'($urandom); imm = $urandom; w_en = 1'($urandom);
      for (int i = 0; i < 20 && busy; i++) @(negedge clk);
      if (busy) check("busy_timeout", busy, 1'b0);
      @(negedge clk);
   endtask

   task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                         input logic [3:0] op, input logic wen, input logic m,
                         input logic [31:0] k);
      issue(a, b, w, op, wen, m, k, 1'b1);
      finish_op();
   endtask

   // Monitor: every done pulse consumes one prediction.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected_done: got done with empty queue, expected none");
         end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            check("sb_res", res, e[35:4]);
            check("sb_flags", flags, e[3:0]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int busy_cnt, done_cnt;
      for (int i = 0; i < 32; i++) mregs[i] = '0;

      repeat (3) @(negedge clk);
      check("rst_res", res, 0);
      check("rst_flags", flags, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Loads then ADD with done-latency measurement.
      run_op(0, 0, 1, 0, 1, 1, 32'd7);
      run_op(0, 0, 2, 0, 1, 1, 32'd5);
      issue(1, 2, 3, 4'd0, 1, 0, 0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1 check("done_latency", done, (i == 3));
      end
      finish_op();
      check("add_res", res, 32'd12);
      check("add_flags", flags, 4'b0000);
      run_op(3, 0, 0, 4'd10, 0, 0, 0);
      check("r3_readback", res, 32'd12);

      // Signed overflow and borrow.
      run_op(0, 0, 1, 0, 1, 1, 32'h7FFF_FFFF);
      run_op(0, 0, 2, 0, 1, 1, 32'd1);
      run_op(1, 2, 3, 4'd0, 1, 0, 0);
      check("ovf_res", res, 32'h8000_0000);
      check("ovf_flags", flags, 4'b0101);
      run_op(2, 1, 3, 4'd1, 1, 0, 0);
      check("sub_res", res, 32'h8000_0002);
      check("sub_flags", flags, 4'b0110);

      // x0 is hardwired zero.
      run_op(0, 0, 0, 0, 1, 1, 32'hDEAD);
      run_op(0, 0, 7, 4'd0, 1, 0, 0);
      check("x0_res", res, 0);
      check("x0_flags", flags, 4'b1000);

      // Held step plus a re-pulse while busy: exactly one operation.
      issue(1, 2, 8, 4'd4, 1, 0, 0, 1'b1);
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk);
         #1;
         busy_cnt += int'(busy);
         done_cnt += int'(done);
         @(negedge clk);
         if (i == 1) step = 1'b0;
         if (i == 2) step = 1'b1;
         if (i == 10) step = 1'b0;
      end
      check("hold_busy_cycles", busy_cnt, 3);
      check("hold_done_count", done_cnt, 1);

      // Shifts and compares.
      run_op(0, 0, 4, 0, 1, 1, 32'h8000_0000);
      run_op(0, 0, 5, 0, 1, 1, 32'd4);
      run_op(4, 5, 0, 4'd7, 0, 0, 0);
      check("sra_res", res, 32'hF800_0000);
      run_op(4, 5, 0, 4'd6, 0, 0, 0);
      check("srl_res", res, 32'h0800_0000);
      run_op(4, 5, 0, 4'd8, 0, 0, 0);
      check("slt_res", res, 32'd1);
      run_op(4, 5, 0, 4'd9, 0, 0, 0);
      check("sltu_res", res, 32'd0);

      // Reserved op.
      run_op(1, 2, 0, 4'd13, 0, 0, 0);
      check("rsvd_flags", flags, 4'b1000);

      // Randomised operations over a small register window to force reuse.
      for (int n = 0; n < 40; n++) begin
         run_op(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), $urandom);
      end

      // Reset during EXEC aborts the write to R6.
      run_op(0, 0, 9, 0, 1, 1, 32'h55);
      issue(0, 0, 6, 0, 1, 1, 32'h1234, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      step  = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_res", res, 0);
      check("abort_flags", flags, 0);
      check("abort_done", done, 0);
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(6, 0, 0, 4'd10, 0, 0, 0);
      check("abort_r6", res, 0);
      run_op(0, 0, 6, 0, 1, 1, 32'hCAFE);
      run_op(6, 0, 0, 4'd10, 0, 0, 0);
      check("post_abort_r6", res, 32'hCAFE);

      repeat (4) @(negedge clk);
      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_regfile_stepper.md
Name: alu_regfile_stepper

Overview:
- Parametrised, single-clock successor to the button-clocked ALU + register-heap datapath.
- One register file and one ALU, sequenced by an internal 4-state FSM.
- Each rising edge on `step` runs one operation: read → execute → writeback.
- `res` and `flags` are registered so they can drive the seven-segment display directly.
- The FSM adds write-enable gating, a load-immediate mode, busy/done status and a hardwired-zero x0. The previous block had none of these.

Parameters:
- XLEN, 32, datapath and register width (≥ 8, power of 2).
- NREG, 32, number of registers (power of 2, ≥ 2).
- AW, $clog2(NREG), register address width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- step  in  1  level request, already synchronised/debounced; its rising edge starts one operation.
- r_addr_a  in  AW  source register A.
- r_addr_b  in  AW  source register B.
- w_addr  in  AW  destination register.
- alu_op  in  4  operation select.
- w_en  in  1  writeback enable.
- mode  in  1  0 = ALU result, 1 = load `imm`.
- imm  in  XLEN  immediate value for mode 1.
- res  out  XLEN  registered result.
- flags  out  4  registered {Z,N,C,V}.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse in WB.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - all registers = 0; res = 0; flags = 0; busy = 0; done = 0.
  - FSM = IDLE; step edge detector history = 0.
  - A reset mid-operation aborts the operation; no write occurs.
- Edge detect: step_q is step registered one cycle; a start is `step & ~step_q` while in IDLE. Edges seen in any other state are dropped, not queued.
- FSM states IDLE → READ → EXEC → WB → IDLE, one cycle each; no stalls.
  - IDLE, start: latch r_addr_a, r_addr_b, w_addr, alu_op, w_en, mode, imm. Inputs may change after this.
  - READ: latch opa = R[a], opb = R[b]. R[0] always reads 0.
  - EXEC: compute, then load res and flags at the end of the cycle.
  - WB: done = 1. If w_en = 1 and w_addr ≠ 0, R[w_addr] = res at the end of WB.
- Latency: start sampled at edge T0; res/flags valid after T2; register write at T3. The next start is accepted at T4 or later, so it reads the new value. There is no forwarding hazard.
- mode = 1: res = imm. Z/N are computed from imm; C = V = 0. alu_op is ignored.
- ALU ops (XLEN-bit, wrap-around):
  - 0 ADD, 1 SUB (a − b).
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = opb[log2(XLEN)−1:0].
  - 8 SLT (signed, result 1/0), 9 SLTU (result 1/0).
  - 10 copy a, 11 NOR.
  - 12–15 reserved: res = 0, Z = 1.
- Flags:
  - Z = (res == 0); N = res[XLEN−1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (a <u b); V = signed overflow.
  - All other ops: C = V = 0.
- res and flags hold their value until the next EXEC.
- Writes to address 0 are silently discarded; this still completes through WB with a done pulse.
- w_en = 0 runs the full sequence and updates res/flags, but performs no register write.

Test Plan:
- Reset, then two mode = 1 steps: imm = 7 → R1 and imm = 5 → R2. Then step ADD a = 1, b = 2, w = 3 → res = 12, flags = 0000, R3 = 12; done pulses exactly 3 cycles after the step edge is sampled.
- Load R1 = 0x7FFFFFFF, R2 = 1; ADD → res = 0x80000000, flags N = 1, V = 1, C = 0. Then SUB R2 − R1 → res = 0x80000002, C = 1 (borrow), V = 0.
- Write to w_addr = 0 with imm = 0xDEAD, then ADD a = 0, b = 0 → res = 0, Z = 1; R0 still reads 0.
- Hold step high for 10 cycles, and pulse step again while busy → exactly one operation runs; busy is high for 3 cycles.
- Load R4 = 0x80000000, then SRA by R5 = 4 → res = 0xF8000000. SRL → 0x08000000. SLT R4, R5 → 1; SLTU → 0.
- Deassert rst_n during EXEC → busy and outputs clear immediately; the target register is unchanged (0). The next step runs normally.
